// File: rtl/reflet_status_collector.sv
// Sticky event-flag collector feeding a read-only status register: per-bit sync/edge/flag
// slices, W1C clear, interrupt mask, saturating lost-event counter and registered bus read.

module reflet_status_collector_bit #(
  parameter bit SYNC = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic ev_in,
  input  logic clr,
  output logic flag,
  output logic lost
);
  logic ev_s, rise;
  logic prev_q, prev_d;
  logic flag_q, flag_d;

  generate
    if (SYNC) begin : g_sync
      logic s1_q, s1_d, s2_q, s2_d;
      always_comb begin
        s1_d = ev_in;
        s2_d = s1_q;
      end
      always_ff @(posedge clk) begin
        if (!reset) begin
          s1_q <= 1'b0;
          s2_q <= 1'b0;
        end else begin
          s1_q <= s1_d;
          s2_q <= s2_d;
        end
      end
      assign ev_s = s2_q;
    end else begin : g_nosync
      assign ev_s = ev_in;
    end
  endgenerate

  assign rise = ev_s & ~prev_q;

  // A rise coinciding with a clear wins, so a freshly arriving event is never dropped.
  always_comb begin
    prev_d = ev_s;
    flag_d = (flag_q & ~clr) | rise;
    lost   = rise & flag_q & ~clr;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      prev_q <= 1'b0;
      flag_q <= 1'b0;
    end else begin
      prev_q <= prev_d;
      flag_q <= flag_d;
    end
  end

  assign flag = flag_q;
endmodule

module reflet_status_collector #(
  parameter int addr_size   = 16,
  parameter int reg_addr    = 0,
  parameter bit sync_inputs = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [addr_size-1:0] addr,
  input  logic                 write_en,
  input  logic [7:0]           data_in,
  output logic [7:0]           data_out,
  input  logic [7:0]           events,
  output logic [7:0]           status,
  output logic                 interrupt
);
  localparam logic [addr_size-1:0] A_FLAGS = addr_size'(reg_addr);
  localparam logic [addr_size-1:0] A_MASK  = addr_size'(reg_addr + 1);
  localparam logic [addr_size-1:0] A_CNT   = addr_size'(reg_addr + 2);

  logic       wr, rd;
  logic [7:0] clr, flags, lost;
  logic [7:0] mask_q, mask_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] dout_q, dout_d;
  logic       irq_q, irq_d;

  assign wr  = enable & write_en;
  assign rd  = enable & ~write_en;
  assign clr = (wr && addr == A_FLAGS) ? data_in : 8'h00;

  generate
    for (genvar i = 0; i < 8; i++) begin : g_bit
      reflet_status_collector_bit #(.SYNC(sync_inputs)) u_bit (
        .clk   (clk),
        .reset (reset),
        .ev_in (events[i]),
        .clr   (clr[i]),
        .flag  (flags[i]),
        .lost  (lost[i])
      );
    end
  endgenerate

  always_comb begin
    mask_d = mask_q;
    if (wr && addr == A_MASK) mask_d = data_in;

    // One count per cycle with any lost edge; a counter write overrides it.
    cnt_d = cnt_q;
    if (wr && addr == A_CNT)             cnt_d = 8'h00;
    else if (|lost && cnt_q != 8'hFF)    cnt_d = cnt_q + 8'd1;

    dout_d = 8'h00;
    if (rd) begin
      if (addr == A_FLAGS)     dout_d = flags;
      else if (addr == A_MASK) dout_d = mask_q;
      else if (addr == A_CNT)  dout_d = cnt_q;
    end

    irq_d = |(flags & mask_q);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      mask_q <= 8'h00;
      cnt_q  <= 8'h00;
      dout_q <= 8'h00;
      irq_q  <= 1'b0;
    end else begin
      mask_q <= mask_d;
      cnt_q  <= cnt_d;
      dout_q <= dout_d;
      irq_q  <= irq_d;
    end
  end

  assign status    = flags;
  assign data_out  = dout_q;
  assign interrupt = irq_q;
endmodule

// File: tb/tb_reflet_status_collector.sv
// Directed bench for reflet_status_collector (sync_inputs=1, reg_addr=0).
module tb_reflet_status_collector;
  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [15:0] addr;
  logic        write_en;
  logic [7:0]  data_in;
  logic [7:0]  data_out;
  logic [7:0]  events;
  logic [7:0]  status;
  logic        interrupt;

  int n_chk = 0;
  int n_pass = 0;

  reflet_status_collector #(.addr_size(16), .reg_addr(0), .sync_inputs(1'b1)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .addr      (addr),
    .write_en  (write_en),
    .data_in   (data_in),
    .data_out  (data_out),
    .events    (events),
    .status    (status),
    .interrupt (interrupt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %02h expected %02h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    enable = 1'b1; write_en = 1'b1; addr = a; data_in = d;
    tick();
    enable = 1'b0; write_en = 1'b0; data_in = 8'h00;
  endtask

  task automatic rd(input logic [15:0] a, input logic [7:0] exp, input string tag);
    enable = 1'b1; write_en = 1'b0; addr = a;
    tick();
    enable = 1'b0;
    chk(tag, data_out, exp);
  endtask

  task automatic pulse(input logic [7:0] m);
    events = m;
    tick();
    events = 8'h00;
    tick();
  endtask

  initial begin
    reset = 1'b0; enable = 1'b0; write_en = 1'b0; addr = '0; data_in = '0; events = 8'hFF;

    // 1: reset with all events held high
    tick(); tick();
    chk("rst_status", status, 8'h00);
    chk("rst_irq", {7'b0, interrupt}, 8'h00);
    chk("rst_dout", data_out, 8'h00);
    reset = 1'b1;
    tick();
    chk("rel_e1", status, 8'h00);
    tick();
    chk("rel_e2", status, 8'h00);
    tick();
    chk("rel_e3", status, 8'hFF);
    events = 8'h00;
    wr(16'd0, 8'hFF);
    chk("clr_all", status, 8'h00);
    wr(16'd2, 8'h00);

    // 2: single pulse on bit 3 with mask 08
    wr(16'd1, 8'h08);
    events = 8'h08;
    tick();
    events = 8'h00;
    tick();
    chk("p3_sync", status, 8'h00);
    tick();
    chk("p3_flag", status, 8'h08);
    chk("p3_irq_lag", {7'b0, interrupt}, 8'h00);
    tick();
    chk("p3_irq", {7'b0, interrupt}, 8'h01);
    wr(16'd0, 8'h08);
    chk("p3_w1c", status, 8'h00);
    tick();
    chk("p3_irq_off", {7'b0, interrupt}, 8'h00);

    // 3: lost-event counter, saturation, clear
    wr(16'd2, 8'h00);
    pulse(8'h01);
    pulse(8'h01);
    tick(); tick(); tick();
    rd(16'd2, 8'h01, "cnt_one");
    for (int i = 0; i < 300; i++) pulse(8'h01);
    tick(); tick(); tick();
    rd(16'd2, 8'hFF, "cnt_sat");
    wr(16'd2, 8'h00);
    rd(16'd2, 8'h00, "cnt_clr");

    // 4: rise on bit 5 in the same cycle as its W1C
    wr(16'd0, 8'hFF);
    wr(16'd2, 8'h00);
    pulse(8'h20);
    tick(); tick(); tick();
    chk("b5_set", status, 8'h20);
    events = 8'h20;
    tick();
    events = 8'h00;
    tick();
    wr(16'd0, 8'h20);
    chk("b5_setwins", status, 8'h20);
    tick();
    rd(16'd2, 8'h00, "b5_notlost");

    // 5: register readback
    wr(16'd0, 8'hFF);
    pulse(8'hA5);
    tick(); tick(); tick();
    wr(16'd1, 8'h3C);
    wr(16'd2, 8'h00);
    for (int i = 0; i < 7; i++) pulse(8'h01);
    tick(); tick(); tick();
    chk("rb_status", status, 8'hA5);
    chk("rb_irq", {7'b0, interrupt}, 8'h01);
    rd(16'd0, 8'hA5, "rd_flags");
    tick();
    chk("rd_idle", data_out, 8'h00);
    rd(16'd1, 8'h3C, "rd_mask");
    rd(16'd2, 8'h07, "rd_cnt");
    rd(16'd3, 8'h00, "rd_other");
    rd(16'd2, 8'h07, "rd_noclr");
    wr(16'd1, 8'h00);
    chk("wr_dout", data_out, 8'h00);

    // 6: reset while everything is set
    wr(16'd1, 8'hFF);
    pulse(8'hFF);
    tick(); tick(); tick();
    chk("pre_status", status, 8'hFF);
    chk("pre_irq", {7'b0, interrupt}, 8'h01);
    reset = 1'b0;
    tick();
    chk("mid_status", status, 8'h00);
    chk("mid_irq", {7'b0, interrupt}, 8'h00);
    reset = 1'b1;
    rd(16'd1, 8'h00, "post_mask");
    rd(16'd2, 8'h00, "post_cnt");
    tick(); tick(); tick();
    chk("post_status", status, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
